// File: rtl/branch_resolver.sv
// branch_resolver: resolve-stage branch evaluation, flush/redirect on mispredict,
// 2-bit-counter outcome strobe and a BTB update queue on a valid/ready port.
// Optional feature: define BR_JUMP_RESOLVE_EN to also resolve JMP/JAL here.
// Opcode map: BEQ=4'h4, BNE=4'h5, BGZ=4'h6, BLZ=4'h7, JMP=4'h8, JAL=4'h9.
module branch_resolver #(
    parameter int FIFO_DEPTH = 4,
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res_valid,
    input  logic [15:0]           res_instr,
    input  logic [15:0]           res_pc,
    input  logic [15:0]           res_pred_pc,
    input  logic [15:0]           res_rs,
    input  logic [15:0]           res_rt,
    output logic                  flush,
    output logic [15:0]           redirect_pc,
    output logic                  cnt_valid,
    output logic                  cnt_taken,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [INDEX_BITS-1:0] upd_index,
    output logic [TAG_BITS-1:0]   upd_tag,
    output logic [15:0]           upd_target,
    output logic                  upd_overflow,
    output logic [15:0]           branch_count,
    output logic [15:0]           mispredict_count
);
    localparam logic [3:0] BEQ_OP = 4'h4;
    localparam logic [3:0] BNE_OP = 4'h5;
    localparam logic [3:0] BGZ_OP = 4'h6;
    localparam logic [3:0] BLZ_OP = 4'h7;
`ifdef BR_JUMP_RESOLVE_EN
    localparam logic [3:0] JMP_OP = 4'h8;
    localparam logic [3:0] JAL_OP = 4'h9;
`endif
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                  flush_q, cnt_valid_q, cnt_taken_q, overflow_q;
    logic [15:0]           redirect_q, br_cnt_q, mp_cnt_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [INDEX_BITS-1:0] idx_mem_q [FIFO_DEPTH];
    logic [TAG_BITS-1:0]   tag_mem_q [FIFO_DEPTH];
    logic [15:0]           tgt_mem_q [FIFO_DEPTH];

    logic        accept, is_cond, is_jump, taken, resolved, mispredict;
    logic        push, pop, full, drop;
    logic [15:0] imm_sext, seq_pc, actual_pc, upd_tgt_d;

`ifndef BR_JUMP_RESOLVE_EN
    // Jump target bits are only consumed when jumps resolve here.
    logic unused_jump_bits;
    assign unused_jump_bits = ^res_instr[11:8];
`endif

    // Decode, evaluate direction and compute the architecturally correct next PC.
    always_comb begin
        accept    = res_valid && !flush_q;
        is_cond   = 1'b0;
        is_jump   = 1'b0;
        taken     = 1'b0;
        imm_sext  = {{8{res_instr[7]}}, res_instr[7:0]};
        seq_pc    = res_pc + 16'd1;
        case (res_instr[15:12])
            BEQ_OP: begin is_cond = 1'b1; taken = (res_rs == res_rt); end
            BNE_OP: begin is_cond = 1'b1; taken = (res_rs != res_rt); end
            BGZ_OP: begin is_cond = 1'b1; taken = ($signed(res_rs) > 16'sd0); end
            BLZ_OP: begin is_cond = 1'b1; taken = res_rs[15]; end
`ifdef BR_JUMP_RESOLVE_EN
            JMP_OP, JAL_OP: begin is_jump = 1'b1; taken = 1'b1; end
`endif
            default: ;
        endcase
        actual_pc = taken ? (seq_pc + imm_sext) : seq_pc;
        if (is_jump)
            actual_pc = {res_pc[15:12], res_instr[11:0]};
        resolved   = accept && (is_cond || is_jump);
        mispredict = resolved && (actual_pc != res_pred_pc);
        upd_tgt_d  = taken ? actual_pc : 16'hFFFF;
    end

    // Queue bookkeeping: a push into a full queue survives only if the head pops.
    always_comb begin
        pop     = (count_q != '0) && upd_ready;
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        push    = mispredict && (!full || pop);
        drop    = mispredict && full && !pop;
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
    end

    // Registered flush/redirect, counter strobe and saturating perf counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            cnt_valid_q <= 1'b0;
            cnt_taken_q <= 1'b0;
            br_cnt_q    <= '0;
            mp_cnt_q    <= '0;
        end else begin
            flush_q     <= mispredict;
            cnt_valid_q <= accept && is_cond;
            cnt_taken_q <= accept && is_cond && taken;
            if (mispredict)
                redirect_q <= actual_pc;
            if (resolved && br_cnt_q != 16'hFFFF)
                br_cnt_q <= br_cnt_q + 16'd1;
            if (mispredict && mp_cnt_q != 16'hFFFF)
                mp_cnt_q <= mp_cnt_q + 16'd1;
        end
    end

    // BTB update FIFO; storage is cleared on reset so idle fields read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                idx_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
                tgt_mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (drop)
                overflow_q <= 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push) begin
                idx_mem_q[wr_ptr_q] <= res_pc[INDEX_BITS-1:0];
                tag_mem_q[wr_ptr_q] <= res_pc[INDEX_BITS +: TAG_BITS];
                tgt_mem_q[wr_ptr_q] <= upd_tgt_d;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
        end
    end

    assign flush            = flush_q;
    assign redirect_pc      = redirect_q;
    assign cnt_valid        = cnt_valid_q;
    assign cnt_taken        = cnt_taken_q;
    assign upd_valid        = (count_q != '0);
    assign upd_index        = idx_mem_q[rd_ptr_q];
    assign upd_tag          = tag_mem_q[rd_ptr_q];
    assign upd_target       = tgt_mem_q[rd_ptr_q];
    assign upd_overflow     = overflow_q;
    assign branch_count     = br_cnt_q;
    assign mispredict_count = mp_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a driver applies stimulus and pushes the
// reference model's expected post-edge outputs; a monitor pops and compares.
module tb_branch_resolver;
    localparam int D = 4;
    localparam logic [3:0] BEQ = 4'h4, BNE = 4'h5, BGZ = 4'h6, BLZ = 4'h7;
    localparam logic [3:0] JMP = 4'h8, JAL = 4'h9;

    logic        clk = 1'b0, reset = 1'b1, res_valid = 1'b0, upd_ready = 1'b0;
    logic [15:0] res_instr = '0, res_pc = '0, res_pred_pc = '0, res_rs = '0, res_rt = '0;
    logic        flush, cnt_valid, cnt_taken, upd_valid, upd_overflow;
    logic [15:0] redirect_pc, upd_target, branch_count, mispredict_count;
    logic [7:0]  upd_index, upd_tag;

    branch_resolver #(.FIFO_DEPTH(D), .INDEX_BITS(8), .TAG_BITS(8)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_instr(res_instr),
        .res_pc(res_pc), .res_pred_pc(res_pred_pc), .res_rs(res_rs), .res_rt(res_rt),
        .flush(flush), .redirect_pc(redirect_pc), .cnt_valid(cnt_valid),
        .cnt_taken(cnt_taken), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_index(upd_index), .upd_tag(upd_tag), .upd_target(upd_target),
        .upd_overflow(upd_overflow), .branch_count(branch_count),
        .mispredict_count(mispredict_count));

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          flush;
        logic [15:0] redirect;
        bit          cv;
        bit          ct;
        logic [15:0] bc;
        logic [15:0] mc;
        bit          uv;
        logic [15:0] ui;
        logic [15:0] ut;
        logic [15:0] utg;
        bit          ovf;
    } exp_t;

    typedef struct {
        logic [15:0] idx;
        logic [15:0] tag;
        logic [15:0] tgt;
    } btb_t;

    exp_t exp_q[$];
    btb_t btb_q[$];
    int   checks = 0, errors = 0;

    bit          m_flush;
    logic [15:0] m_redirect;
    int          m_bc, m_mc;
    bit          m_ovf;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural branch semantics from the ISA rules, with plain integer arithmetic.
    function automatic void ref_resolve(input logic [15:0] instr, pc, rs, rt,
                                        output bit is_res, output bit is_cond,
                                        output bit tk, output logic [15:0] nxt);
        int imm, srs;
        logic [7:0] imm8;
        imm8 = instr[7:0];
        imm  = imm8[7] ? int'(imm8) - 256 : int'(imm8);
        srs  = rs[15] ? int'(rs) - 65536 : int'(rs);
        is_res = 0; is_cond = 0; tk = 0;
        case (instr[15:12])
            BEQ: begin is_cond = 1; tk = (rs == rt); end
            BNE: begin is_cond = 1; tk = (rs != rt); end
            BGZ: begin is_cond = 1; tk = (srs > 0); end
            BLZ: begin is_cond = 1; tk = (srs < 0); end
            default: ;
        endcase
        is_res = is_cond;
        nxt = 16'(int'(pc) + 1 + (tk ? imm : 0));
`ifdef BR_JUMP_RESOLVE_EN
        if (instr[15:12] == JMP || instr[15:12] == JAL) begin
            is_res = 1; tk = 1;
            nxt = {pc[15:12], instr[11:0]};
        end
`endif
    endfunction

    task automatic step(input bit rst, input bit v, input logic [15:0] instr, pc, pred,
                        rs, rt, input bit rdy);
        exp_t e;
        bit is_res, is_cond, tk, acc, misp, pp;
        logic [15:0] nxt;
        int sz;
        @(negedge clk);
        reset = rst; res_valid = v; res_instr = instr; res_pc = pc;
        res_pred_pc = pred; res_rs = rs; res_rt = rt; upd_ready = rdy;
        e = '{default: '0};
        if (rst) begin
            m_flush = 0; m_redirect = 0; m_bc = 0; m_mc = 0; m_ovf = 0;
            btb_q.delete();
            e.rst = 1;
            exp_q.push_back(e);
            return;
        end
        ref_resolve(instr, pc, rs, rt, is_res, is_cond, tk, nxt);
        acc  = v && !m_flush;
        misp = acc && is_res && (nxt != pred);
        if (acc && is_res && m_bc < 65535) m_bc++;
        if (misp && m_mc < 65535) m_mc++;
        if (misp) m_redirect = nxt;
        m_flush = misp;
        sz = btb_q.size();
        pp = (sz > 0) && rdy;
        if (pp) void'(btb_q.pop_front());
        if (misp) begin
            if (sz == D && !pp) m_ovf = 1;
            else btb_q.push_back('{idx: {8'h00, pc[7:0]}, tag: {8'h00, pc[15:8]},
                                   tgt: tk ? nxt : 16'hFFFF});
        end
        e.flush = misp; e.redirect = m_redirect;
        e.cv = acc && is_cond; e.ct = acc && is_cond && tk;
        e.bc = 16'(m_bc); e.mc = 16'(m_mc); e.ovf = m_ovf;
        e.uv = btb_q.size() > 0;
        if (e.uv) begin
            e.ui = btb_q[0].idx; e.ut = btb_q[0].tag; e.utg = btb_q[0].tgt;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, rdy);
    endtask

    // Monitor: compares every presented output cycle against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("flush", {15'd0, flush}, {15'd0, e.flush});
                check("redirect_pc", redirect_pc, e.redirect);
                check("cnt_valid", {15'd0, cnt_valid}, {15'd0, e.cv});
                if (e.cv) check("cnt_taken", {15'd0, cnt_taken}, {15'd0, e.ct});
                check("branch_count", branch_count, e.bc);
                check("mispredict_count", mispredict_count, e.mc);
                check("upd_valid", {15'd0, upd_valid}, {15'd0, e.uv});
                check("upd_overflow", {15'd0, upd_overflow}, {15'd0, e.ovf});
                if (e.uv || e.rst) begin
                    check("upd_index", {8'd0, upd_index}, e.ui);
                    check("upd_tag", {8'd0, upd_tag}, e.ut);
                    check("upd_target", upd_target, e.utg);
                end
                if (e.rst) check("cnt_taken_rst", {15'd0, cnt_taken}, 16'd0);
            end
        end
    end

    initial begin
        logic [15:0] instr, pc, pred, rs, rt, nxt;
        bit is_res, is_cond, tk;
        logic [3:0] ops [8];
        ops = '{BEQ, BNE, BGZ, BLZ, JMP, JAL, 4'h0, 4'hF};

        step(1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0);
        // BEQ taken, mispredicted, followed by a shadowed BEQ.
        step(0, 1, {BEQ, 4'h0, 8'h05}, 16'h0010, 16'h0011, 16'd3, 16'd3, 0);
        step(0, 1, {BEQ, 4'h0, 8'h05}, 16'h0010, 16'h0011, 16'd3, 16'd3, 0);
        idle(1);
        step(0, 1, {BNE, 4'h0, 8'h10}, 16'h0120, 16'h0121, 16'd7, 16'd7, 1);
        step(0, 1, {BLZ, 4'h0, 8'hFE}, 16'h0200, 16'h01FF, 16'hFFFF, 16'd0, 1);
        step(0, 1, {BGZ, 4'h0, 8'h20}, 16'h0305, 16'h0300, 16'd0, 16'd0, 0);
        idle(0);
        // Fill past capacity with ready held low, then drain.
        for (int i = 0; i < 4; i++) begin
            step(0, 1, {BEQ, 4'h0, 8'h03}, 16'h0400 + 16'(i), 16'h0000, 16'd1, 16'd1, 0);
            idle(0);
        end
        for (int i = 0; i < 6; i++) idle(1);
        // Two queued entries, then reset concurrent with a mispredict.
        step(0, 1, {BNE, 4'h0, 8'h08}, 16'h0500, 16'h0000, 16'd1, 16'd2, 0);
        idle(0);
        step(0, 1, {BNE, 4'h0, 8'h08}, 16'h0510, 16'h0000, 16'd1, 16'd2, 0);
        idle(0);
        step(1, 1, {BEQ, 4'h0, 8'h08}, 16'h0520, 16'h0000, 16'd4, 16'd4, 0);
        idle(0);
        idle(1);
        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            instr = {ops[$urandom_range(0, 7)], 12'($urandom)};
            pc    = 16'($urandom);
            rs    = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            rt    = ($urandom_range(0, 2) == 0) ? rs : 16'($urandom);
            ref_resolve(instr, pc, rs, rt, is_res, is_cond, tk, nxt);
            pred  = ($urandom_range(0, 1) == 1) ? nxt : 16'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, instr, pc, pred,
                 rs, rt, $urandom_range(0, 2) != 0);
        end
        idle(1);
        for (int w = 0; w < 20 && exp_q.size() > 0; w++) begin
            @(posedge clk);
            #2;
        end
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolve-stage partner of the fetch-side branch predictor. It evaluates each conditional branch against forwarded operands, computes the actual next PC, and compares it with the PC the predictor chose. On a mismatch it raises a registered flush/redirect. It also produces the two update streams the predictor consumes: a 2-bit-counter outcome pulse, and queued BTB write/invalidate commands delivered over a valid/ready port.

## Interface

Parameters:
- `FIFO_DEPTH`, 4: BTB update queue entries; power of two, ≥2.
- `INDEX_BITS`, 8: BTB index width, taken from `PC[INDEX_BITS-1:0]`.
- `TAG_BITS`, 8: BTB tag width, taken from `PC[15:INDEX_BITS]`.

Ports (`WORD_SIZE` = 16):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `res_valid` in 1: an instruction occupies the resolve stage this cycle.
- `res_instr` in 16: instruction word; opcode is `[15:12]`, imm8 is `[7:0]`.
- `res_pc` in 16: PC of that instruction.
- `res_pred_pc` in 16: next PC the predictor fetched after it.
- `res_rs`, `res_rt` in 16 each: forwarded operands.
- `flush` out 1: squash younger stages.
- `redirect_pc` out 16: fetch PC to use when `flush` is high.
- `cnt_valid` out 1: counter-update strobe.
- `cnt_taken` out 1: resolved direction.
- `upd_valid` out 1: BTB update pending.
- `upd_ready` in 1: predictor accepts the update.
- `upd_index` out INDEX_BITS: BTB index of the update.
- `upd_tag` out TAG_BITS: BTB tag of the update.
- `upd_target` out 16: target written to the BTB entry; 16'hFFFF means invalidate.
- `upd_overflow` out 1: sticky; an update was dropped.
- `branch_count` out 16: resolved-branch counter, saturating.
- `mispredict_count` out 16: mispredict counter, saturating.

## Operation

- **Resolvable ops:** `BNE_OP`, `BEQ_OP`, `BGZ_OP`, `BLZ_OP`. Other opcodes produce no action.
- **Direction:**
  - BNE: rs≠rt.
  - BEQ: rs==rt.
  - BGZ: signed rs>0.
  - BLZ: signed rs<0.
- **Actual next PC:** taken → `res_pc + 1 + sext(imm8)`; not taken → `res_pc + 1`. Arithmetic is 16-bit and wraps modulo 2^16.
- **Shadow:** `res_valid` is ignored in any cycle where `flush` is high, because that slot holds a wrong-path instruction.
- **Mispredict:** actual ≠ `res_pred_pc`. Then `flush`=1 and `redirect_pc`=actual, and `mispredict_count` increments.
- **Counters:** every accepted branch increments `branch_count`. `cnt_valid`=1 with `cnt_taken`=direction.
- **BTB update enqueue, only on mispredict:**
  - Taken: enqueue {index, tag, target}.
  - Not taken: enqueue {index, tag, 16'hFFFF} (invalidate a stale hit).
  - Index and tag come from `res_pc`.
  - A correct prediction enqueues nothing.
- **Queue:** circular FIFO.
  - `upd_valid` = not empty; the head drives the `upd_*` fields.
  - Pop on `upd_valid && upd_ready`.
  - Full with push and no pop: the new entry is dropped and `upd_overflow` sets. It clears only on reset.
  - Full with simultaneous push and pop: both complete and the count is unchanged.
  - Empty with push: the entry appears on the next cycle. There is no same-cycle bypass.
- **Handshake:** `upd_*` fields are held stable while `upd_valid && !upd_ready`.
- **Saturation:** perf counters hold at 16'hFFFF.

## Timing

- All outputs are registered.
- Resolution in cycle N produces:
  - `flush`, `redirect_pc`, `cnt_valid`, `cnt_taken`, and the counter updates in cycle N+1;
  - the pushed entry visible on `upd_*` in cycle N+1 if the queue was empty.
- `flush` and `cnt_valid` are one-cycle pulses. `redirect_pc` holds its last value when `flush` is low.
- Back-to-back branches are accepted every cycle except in the flush shadow.
- Reset values:
  - `flush`, `cnt_valid`, `cnt_taken`, `upd_valid`, `upd_overflow` = 0.
  - `redirect_pc`, `upd_index`, `upd_tag`, `upd_target`, both counters = 0.
  - Queue pointers cleared.
- Reset mid-operation: queued entries and any pending flush are discarded, and nothing is emitted the following cycle.

## Configuration

- `BR_JUMP_RESOLVE_EN` defined: `JMP_OP` and `JAL_OP` are also resolved.
  - They are always taken, with target `{res_pc[15:12], res_instr[11:0]}`.
  - A target ≠ `res_pred_pc` produces flush and a BTB write.
  - They count in `branch_count` but do not assert `cnt_valid`.
- Undefined: jumps produce no action; the front end handles them.

## Test plan

- BEQ, pc 0x0010, imm 0x05, rs=rt=3, pred 0x0011: next cycle `flush`=1, `redirect_pc`=0x0016, `cnt_taken`=1; upd index 0x10, tag 0x00, target 0x0016; mispredict_count=1.
- BNE, pc 0x0120, rs=rt=7, pred 0x0121: `flush`=0, `cnt_valid`=1, `cnt_taken`=0, `upd_valid` stays 0, branch_count increments.
- BLZ, pc 0x0200, rs=0xFFFF, imm 0xFE, pred 0x01FF: correct prediction, no flush, no upd.
  - Next-cycle BEQ with `res_valid` during a prior flush: ignored, no counters move.
- BGZ, pc 0x0305, rs=0, pred 0x0300: `flush`, `redirect_pc`=0x0306; upd index 0x05, tag 0x03, target 0xFFFF.
- `upd_ready`=0 with 5 consecutive mispredicts: 4 entries held, `upd_overflow`=1, 5th dropped.
  - Then `upd_ready`=1: 4 entries drain in order over 4 cycles, then `upd_valid`=0.
- Reset for 1 cycle with 2 entries queued and a mispredict in resolve: the following cycle all outputs are 0 and the queue is empty.
